// File: rtl/fpm_pkg.sv
// -----------------------------------------------------------------------------
// fpm_pkg
// Shared definitions for the FPM host sequencer and its helpers.
//   - default IEEE-754 single-precision field widths and total word width
//   - sequencer state encoding (IDLE, ISSUE, WAIT, HOLD)
//   - bit positions inside the 3-bit exception class vector
// -----------------------------------------------------------------------------
package fpm_pkg;

  localparam int FPM_EXP_W = 8;
  localparam int FPM_MAN_W = 23;
  localparam int FPM_W     = 1 + FPM_EXP_W + FPM_MAN_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int EXC_ZERO = 0;
  localparam int EXC_INF  = 1;
  localparam int EXC_NAN  = 2;

endpackage

// File: rtl/fpm_result_classify.sv
// -----------------------------------------------------------------------------
// fpm_result_classify
// Purely combinational decoder of the exponent/mantissa fields of an
// IEEE-754 style word into a {nan, inf, zero} class vector. The sign bit
// does not affect the class, so only exponent and mantissa are taken in.
//
// Ports:
//   exp_i  in  EXP_W  exponent field
//   man_i  in  MAN_W  mantissa field
//   exc_o  out 3      class vector, bit positions EXC_ZERO/EXC_INF/EXC_NAN
// -----------------------------------------------------------------------------
module fpm_result_classify
  import fpm_pkg::*;
#(
  parameter int EXP_W = FPM_EXP_W,
  parameter int MAN_W = FPM_MAN_W
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] man_i,
  output logic [2:0]       exc_o
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  assign exp_zero = (exp_i == '0);
  assign exp_ones = &exp_i;
  assign man_zero = (man_i == '0);

  // Denormals (exp==0, man!=0) and ordinary numbers map to no class bit.
  always_comb begin
    exc_o           = 3'b000;
    exc_o[EXC_ZERO] = exp_zero & man_zero;
    exc_o[EXC_INF]  = exp_ones & man_zero;
    exc_o[EXC_NAN]  = exp_ones & ~man_zero;
  end

endmodule

// File: rtl/fpm_host_sequencer.sv
// -----------------------------------------------------------------------------
// fpm_host_sequencer
// Initiator side of the pipelined floating-point multiplier control interface.
// Takes one operand pair over a valid/ready handshake, pulses fpm_start for a
// single cycle, waits for fpm_flag (guarded by a watchdog), then holds the
// captured product on a valid/ready output until the consumer takes it.
// Only one transaction is ever in flight.
//
// Optional build macro:
//   FPM_EXC_DETECT_EN  when defined, out_exc carries the {nan,inf,zero} class
//                      of the captured product; otherwise out_exc is 3'b000.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a/in_b operands
//   fpm_start             one-cycle start pulse to the multiplier
//   fpm_a/fpm_b           operands held for the multiplier
//   fpm_flag/fpm_result   multiplier done flag and product
//   out_valid/out_ready   result handshake; out_result product (0 on timeout)
//   out_timeout           multiplier did not respond within TIMEOUT cycles
//   out_exc               result class {nan,inf,zero}
//   busy                  sequencer is not idle
//
// Parameters: EXP_W, MAN_W field widths; TIMEOUT watchdog limit (>= 2).
// -----------------------------------------------------------------------------
module fpm_host_sequencer
  import fpm_pkg::*;
#(
  parameter  int EXP_W   = FPM_EXP_W,
  parameter  int MAN_W   = FPM_MAN_W,
  parameter  int TIMEOUT = 16,
  localparam int W       = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         fpm_start,
  output logic [W-1:0] fpm_a,
  output logic [W-1:0] fpm_b,
  input  logic         fpm_flag,
  input  logic [W-1:0] fpm_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_timeout,
  output logic [2:0]   out_exc,
  output logic         busy
);

  // Watchdog counter only has to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready_q;
  logic             fpm_start_q;
  logic             out_valid_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     res_q;
  logic             tmo_q;

  logic             accept;
  logic             capture;
  logic             expire;

  // Handshake qualification. A flag seen outside WAIT is never acted on.
  assign accept  = (state_q == ST_IDLE) & in_valid & in_ready_q;
  assign capture = (state_q == ST_WAIT) & fpm_flag;
  // The flag has priority when it coincides with the last watchdog cycle.
  assign expire  = (state_q == ST_WAIT) & ~fpm_flag & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter is frozen on the exit cycle, so it can never wrap.
        if (capture || expire) state_d = ST_HOLD;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers. Handshake outputs are registered from the next state
  // so that every output is low while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      fpm_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == ST_IDLE);
      fpm_start_q <= (state_d == ST_ISSUE);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  // Operand and result registers. Operands change only on acceptance;
  // the result changes only when WAIT is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (capture) begin
        res_q <= fpm_result;
        tmo_q <= 1'b0;
      end else if (expire) begin
        res_q <= '0;
        tmo_q <= 1'b1;
      end
    end
  end

`ifdef FPM_EXC_DETECT_EN
  logic [2:0] exc_class;
  logic [2:0] exc_q;

  fpm_result_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .exp_i (fpm_result[W-2 -: EXP_W]),
    .man_i (fpm_result[MAN_W-1:0]),
    .exc_o (exc_class)
  );

  // Class is captured alongside the product; a timeout carries no class.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q <= 3'b000;
    end else if (capture) begin
      exc_q <= exc_class;
    end else if (expire) begin
      exc_q <= 3'b000;
    end
  end

  assign out_exc = exc_q;
`else
  assign out_exc = 3'b000;
`endif

  assign in_ready    = in_ready_q;
  assign fpm_start   = fpm_start_q;
  assign fpm_a       = a_q;
  assign fpm_b       = b_q;
  assign out_valid   = out_valid_q;
  assign out_result  = res_q;
  assign out_timeout = tmo_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpm_host_sequencer.sv
module tb_fpm_host_sequencer;

  localparam int TIMEOUT = 16;
`ifdef FPM_EXC_DETECT_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        fpm_start;
  logic [31:0] fpm_a, fpm_b;
  logic        fpm_flag;
  logic [31:0] fpm_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_timeout;
  logic [2:0]  out_exc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpm_host_sequencer #(
    .EXP_W   (8),
    .MAN_W   (23),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .fpm_start   (fpm_start),
    .fpm_a       (fpm_a),
    .fpm_b       (fpm_b),
    .fpm_flag    (fpm_flag),
    .fpm_result  (fpm_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_timeout (out_timeout),
    .out_exc     (out_exc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the flag is honoured only while in WAIT, which spans
  // cycles 2 .. 1+TIMEOUT after acceptance; the flag of latency L lands in
  // cycle 1+L, so 1 <= L <= TIMEOUT returns data at 2+L, otherwise the
  // watchdog fires and the result appears at 2+TIMEOUT.
  function automatic bool_ok(input int lat);
    return (lat >= 1) && (lat <= TIMEOUT);
  endfunction

  function automatic int model_vcyc(input int lat);
    return bool_ok(lat) ? 2 + lat : 2 + TIMEOUT;
  endfunction

  function automatic logic [2:0] model_class(input logic [31:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[30:23] == 8'h00 && v[22:0] == 23'd0) r = 3'b001;
    else if (v[30:23] == 8'hFF) r = (v[22:0] == 23'd0) ? 3'b010 : 3'b100;
    return r;
  endfunction

  function automatic logic [2:0] model_exc(input logic [31:0] v, input int lat);
    return (EXC_EN && bool_ok(lat)) ? model_class(v) : 3'b000;
  endfunction

  // Drives one transaction with an FPM that flags `lat` cycles after the
  // start pulse (lat < 0: never), holds out_ready low for `bp` cycles after
  // out_valid, and reports what it observed.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] val, input int lat, input int bp,
                        output int nstart, output int scyc, output int vcyc,
                        output logic [31:0] res, output logic tmo,
                        output logic [2:0] exc, output bit ops_ok,
                        output bit hold_ok, output bit idle_ok);
    int w;
    nstart = 0; scyc = -1; vcyc = -1; res = '0; tmo = 1'b0; exc = 3'b000;
    ops_ok = 1'b1; hold_ok = 1'b1; idle_ok = 1'b0;
    out_ready = (bp == 0);
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin step(); w++; end
    in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (fpm_start === 1'b1) begin
        nstart++;
        if (scyc < 0) scyc = c;
      end
      if (out_valid === 1'b1) begin
        vcyc = c; res = out_result; tmo = out_timeout; exc = out_exc;
        break;
      end
      if (fpm_a !== a || fpm_b !== b) ops_ok = 1'b0;
      if (scyc >= 0 && lat >= 0 && c == scyc + lat) begin
        fpm_flag = 1'b1; fpm_result = val;
      end else begin
        fpm_flag = 1'b0; fpm_result = $urandom;
      end
      step();
    end
    fpm_flag = 1'b0;
    if (vcyc > 0) begin
      for (int k = 0; k < bp; k++) begin
        fpm_flag = 1'($urandom_range(0, 1)); fpm_result = $urandom;
        step();
        if (out_valid !== 1'b1 || out_result !== res || out_timeout !== tmo ||
            out_exc !== exc || in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
      end
      fpm_flag = 1'b0; out_ready = 1'b1;
      step();
      idle_ok = (out_valid === 1'b0) && (in_ready === 1'b1) && (busy === 1'b0);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
    fpm_flag = 1'b1; fpm_result = 32'h7F800000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({in_ready, fpm_start, fpm_a, fpm_b, out_valid, out_result,
           out_timeout, out_exc, busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got rdy=%b st=%b a=%h b=%h v=%b r=%h t=%b e=%b busy=%b want all 0",
                 i, in_ready, fpm_start, fpm_a, fpm_b, out_valid, out_result, out_timeout, out_exc, busy);
      end
    end
    rst = 1'b0; in_valid = 1'b0; fpm_flag = 1'b0; out_ready = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    do_txn(32'h40000000, 32'h40400000, 32'h40C00000, 3, 0, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
    checks++;
    if (ns !== 1 || sc !== 1) begin
      errors++; $display("FAIL basic_start got count=%0d cycle=%0d want 1 1", ns, sc);
    end
    checks++;
    if (vc !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", vc); end
    checks++;
    if (r !== 32'h40C00000 || t !== 1'b0) begin
      errors++; $display("FAIL basic_result got %h tmo=%b want 40c00000 tmo=0", r, t);
    end
    checks++;
    if (!ok_o || !ok_i) begin
      errors++; $display("FAIL basic_operands_idle got ops=%0d idle=%0d want 1 1", ok_o, ok_i);
    end
  endtask

  task automatic test_backpressure();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    do_txn(32'h3FC00000, 32'h40800000, 32'h40C00000, 5, 10, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
    checks++;
    if (vc !== 7 || r !== 32'h40C00000) begin
      errors++; $display("FAIL bp_result got cycle=%0d r=%h want 7 40c00000", vc, r);
    end
    checks++;
    if (!ok_h) begin errors++; $display("FAIL bp_hold_stable got 0 want 1"); end
    checks++;
    if (!ok_i) begin errors++; $display("FAIL bp_release_idle got 0 want 1"); end
  endtask

  task automatic test_timeout();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    int lats [3] = '{-1, TIMEOUT, TIMEOUT + 1};
    logic [31:0] v;
    foreach (lats[i]) begin
      v = 32'h7F800000;
      do_txn($urandom, $urandom, v, lats[i], 1, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
      checks++;
      if (vc !== model_vcyc(lats[i])) begin
        errors++; $display("FAIL timeout_cycle lat=%0d got %0d want %0d", lats[i], vc, model_vcyc(lats[i]));
      end
      checks++;
      if (r !== (bool_ok(lats[i]) ? v : 32'h0) || t !== !bool_ok(lats[i]) ||
          e !== model_exc(v, lats[i])) begin
        errors++;
        $display("FAIL timeout_result lat=%0d got r=%h t=%b e=%b want r=%h t=%b e=%b", lats[i], r, t, e,
                 bool_ok(lats[i]) ? v : 32'h0, !bool_ok(lats[i]), model_exc(v, lats[i]));
      end
      checks++;
      if (!ok_h || !ok_i) begin
        errors++; $display("FAIL timeout_handshake lat=%0d got hold=%0d idle=%0d want 1 1", lats[i], ok_h, ok_i);
      end
    end
  endtask

  task automatic test_stray_flag();
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fpm_flag = 1'b1; fpm_result = $urandom;
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || fpm_start !== 1'b0) seen = 1'b1;
    end
    fpm_flag = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL stray_flag_idle got activity=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    bit bad = 1'b0;
    in_valid = 1'b1; in_a = 32'h41200000; in_b = 32'hC0A00000;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b1 || fpm_a !== 32'h41200000) begin
      errors++; $display("FAIL midreset_pre got busy=%b a=%h want 1 41200000", busy, fpm_a);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({in_ready, fpm_start, fpm_a, fpm_b, out_valid, out_result,
           out_timeout, out_exc, busy} !== '0) begin
        errors++; $display("FAIL midreset_outputs cycle %0d got nonzero outputs busy=%b a=%h want all 0", i, busy, fpm_a);
      end
    end
    rst = 1'b0; fpm_flag = 1'b1; fpm_result = 32'h42C80000;
    step();
    fpm_flag = 1'b0;
    for (int i = 0; i < TIMEOUT + 6; i++) begin
      if (out_valid !== 1'b0 || fpm_start !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_late_flag got output activity want none"); end
    do_txn(32'h40000000, 32'h40000000, 32'h40800000, 2, 0, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
    checks++;
    if (vc !== 4 || r !== 32'h40800000 || t !== 1'b0 || !ok_i) begin
      errors++; $display("FAIL midreset_next_txn got cycle=%0d r=%h t=%b idle=%0d want 4 40800000 0 1", vc, r, t, ok_i);
    end
  endtask

  task automatic test_exc();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    logic [31:0] vals [3] = '{32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [2:0]  cls  [3] = '{3'b100, 3'b010, 3'b001};
    foreach (vals[i]) begin
      do_txn($urandom, $urandom, vals[i], 4, 2, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
      checks++;
      if (e !== (EXC_EN ? cls[i] : 3'b000) || r !== vals[i]) begin
        errors++; $display("FAIL exc_class val=%h got e=%b r=%h want e=%b", vals[i], e, r, EXC_EN ? cls[i] : 3'b000);
      end
    end
  endtask

  task automatic test_random();
    int ns, sc, vc; logic [31:0] r; logic t; logic [2:0] e; bit ok_o, ok_h, ok_i;
    logic [31:0] specials [5] = '{32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h00000001, 32'h3F800000};
    logic [31:0] a, b, v, want_r;
    int lat, bp;
    for (int n = 0; n < 30; n++) begin
      a = $urandom; b = $urandom;
      v = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      lat = $urandom_range(0, TIMEOUT + 3);
      bp = $urandom_range(0, 3);
      do_txn(a, b, v, lat, bp, ns, sc, vc, r, t, e, ok_o, ok_h, ok_i);
      want_r = bool_ok(lat) ? v : 32'h0;
      checks++;
      if (ns !== 1 || sc !== 1 || vc !== model_vcyc(lat)) begin
        errors++; $display("FAIL rand_timing n=%0d lat=%0d got starts=%0d s=%0d v=%0d want 1 1 %0d", n, lat, ns, sc, vc, model_vcyc(lat));
      end
      checks++;
      if (r !== want_r || t !== !bool_ok(lat) || e !== model_exc(v, lat)) begin
        errors++; $display("FAIL rand_result n=%0d lat=%0d got r=%h t=%b e=%b want r=%h t=%b e=%b", n, lat, r, t, e, want_r, !bool_ok(lat), model_exc(v, lat));
      end
      checks++;
      if (!ok_o || !ok_h || !ok_i) begin
        errors++; $display("FAIL rand_handshake n=%0d got ops=%0d hold=%0d idle=%0d want 1 1 1", n, ok_o, ok_h, ok_i);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    fpm_flag = 1'b0; fpm_result = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_stray_flag();
    test_reset_mid();
    test_exc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpm_host_sequencer.md
Name: fpm_host_sequencer

Overview:
- Initiator side of the pipelined floating-point multiplier (FPM) control interface.
- Accepts an operand pair over a valid/ready input handshake and drives the operands plus a one-cycle `fpm_start` pulse into the FPM.
- Waits for the FPM done flag, captures the product, and presents it over a valid/ready output handshake.
- A watchdog reports a hung multiplier so the host never stalls forever.

Parameters:
- EXP_W, 8, exponent field width of operands/result.
- MAN_W, 23, mantissa field width; total word width W = 1+EXP_W+MAN_W (32).
- TIMEOUT, 16, max cycles spent in WAIT before declaring timeout; legal range ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept operands
- in_a  in  W  operand A (IEEE-754 layout)
- in_b  in  W  operand B
- fpm_start  out  1  one-cycle start pulse to FPM
- fpm_a  out  W  operand A to FPM, held stable ISSUE..WAIT
- fpm_b  out  W  operand B to FPM, held stable ISSUE..WAIT
- fpm_flag  in  1  FPM done/flag, high when fpm_result is valid
- fpm_result  in  W  FPM product
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  W  captured product (0 on timeout)
- out_timeout  out  1  qualifies out_result: FPM failed to respond
- out_exc  out  3  result class {nan,inf,zero}; see Optional Feature
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge) sets state to IDLE and clears the watchdog counter and the operand/result registers.
  - Every output is 0 during reset, including in_ready.
  - in_ready rises the first cycle after rst deasserts.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_a/in_b, then go to ISSUE.
  - ISSUE: fpm_start=1 for exactly this cycle (registered output). Clear the counter, then go to WAIT.
  - WAIT: counter increments each cycle.
    - fpm_flag=1: capture fpm_result into out_result, set out_timeout=0, go to HOLD.
    - Else if counter == TIMEOUT-1: set out_result=0, out_timeout=1, go to HOLD.
    - flag and timeout in the same cycle: flag wins.
  - HOLD: out_valid=1; out_result, out_timeout and out_exc are stable. On out_ready, go to IDLE; out_valid is 0 the next cycle.
- in_ready=0 in ISSUE, WAIT and HOLD. There is no input/output overlap: one transaction in flight.
- fpm_a/fpm_b drive the operand registers continuously. The registers change only on input acceptance.
- fpm_flag outside WAIT (stale or stray) is ignored and has no state effect.
- Latency:
  - Accept at edge 0; fpm_start high cycle 1.
  - FPM raises flag L cycles after start; out_valid high the cycle after flag is sampled, i.e. cycle 2+L.
- Counter width is clog2(TIMEOUT), and it never wraps: leaving WAIT always happens at or before TIMEOUT-1.
- Reset mid-operation (any state) aborts the transaction. No output is produced, and a late fpm_flag after reset is ignored.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: FPM_EXC_DETECT_EN.
- Defined: out_exc is registered together with out_result when captured in WAIT.
  - bit0 zero: exp==0 & man==0.
  - bit1 inf: exp all-ones & man==0.
  - bit2 nan: exp all-ones & man!=0.
  - out_exc is 0 on timeout.
- Undefined: out_exc is tied to 3'b000 and the classifier logic is absent.

Decomposition:
- Shared package fpm_pkg:
  - state encoding (IDLE, ISSUE, WAIT, HOLD);
  - EXP_W/MAN_W defaults and W;
  - exc bit indices (EXC_ZERO=0, EXC_INF=1, EXC_NAN=2).
- One natural sub-module: fpm_result_classify, a combinational field decoder instantiated only under FPM_EXC_DETECT_EN.
- FSM and watchdog stay in the top module.

Test Plan:
- Basic multiply:
  - Stimulus: in_a=0x40000000 (2.0), in_b=0x40400000 (3.0). The FPM model asserts flag 3 cycles after start with 0x40C00000.
  - Response: fpm_start pulses exactly once, cycle 1; out_valid at cycle 5 with out_result=0x40C00000 and out_timeout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Response: out_valid and out_result stay constant and in_ready stays 0. After out_ready=1, IDLE follows next cycle with in_ready=1.
- Timeout:
  - Stimulus: TIMEOUT=16, the FPM never flags.
  - Response: out_valid with out_timeout=1 and out_result=0 exactly 16 cycles after entering WAIT.
  - Variant: flag on the same cycle the counter equals 15 gives out_timeout=0 with the real result.
- Stray flag and reset:
  - Stimulus: fpm_flag=1 while in IDLE.
  - Response: no out_valid.
  - Stimulus: rst=1 during WAIT, then the FPM flags 2 cycles later.
  - Response: all outputs are 0 during reset, no out_valid, and the next transaction completes normally.
- Exceptions (macro defined):
  - FPM returns 0x7FC00000 → out_exc=3'b100.
  - FPM returns 0x7F800000 → out_exc=3'b010.
  - FPM returns 0x00000000 → out_exc=3'b001.
  - Macro undefined: out_exc=0 in all three cases.
